pdm_counter: RTL and testbench

Front-end stage for one PDM microphone channel. It generates the microphone bit clock, samples the 1-bit PDM stream, and counts the ones over fixed, non-overlapping windows. At the end of each window it presents the 10-bit count on `cntr` with a one-cycle `cntr_valid` strobe, which directly drives the `cntr`/`cntr_valid` inputs of the downstream `Threshold` detector.

---
 rtl/pdm_counter.sv | 99 +++++++++
 tb/tb_pdm_counter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_counter.sv
`default_nettype none
// ============================================================================
// Module      : pdm_counter
// Description : PDM microphone front end. Generates the bit clock, samples
//               the 1-bit stream at the end of each pdm_clk high phase, and
//               reports the ones-count of fixed non-overlapping windows with
//               a one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_counter #(
  parameter int unsigned CLK_DIV = 4,    // clk cycles per pdm_clk period, even, >= 2
  parameter int unsigned WINDOW  = 1023  // samples per window, 1..1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pdm_data,
  output logic       pdm_clk,
  output logic [9:0] cntr,
  output logic       cntr_valid
);

  localparam int unsigned c_div_w = $clog2(CLK_DIV);

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);
  localparam logic [9:0]         c_win_last = 10'(WINDOW - 1);

  logic [c_div_w-1:0] div_cnt_q, div_cnt_d;
  logic               pdm_clk_q, pdm_clk_d;
  logic [9:0]         ones_q, ones_d;
  logic [9:0]         samp_cnt_q, samp_cnt_d;
  logic [9:0]         cntr_q, cntr_d;
  logic               cntr_valid_q, cntr_valid_d;
  logic               strobe;
  logic [9:0]         ones_sum;

  // Next-state: divider, clock phase, sample strobe and window accumulation.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    pdm_clk_d    = pdm_clk_q;
    ones_d       = ones_q;
    samp_cnt_d   = samp_cnt_q;
    cntr_d       = cntr_q;
    cntr_valid_d = 1'b0;
    // pdm_clk is high while div_cnt_q < CLK_DIV/2, so the edge that leaves
    // div_cnt_q == CLK_DIV/2 behind is the one where pdm_clk falls.
    strobe       = en && (div_cnt_q == c_div_half);
    ones_sum     = ones_q + {9'd0, pdm_data};

    if (!en) begin
      // Disabled: discard the partial window, keep the last reported count.
      div_cnt_d  = '0;
      pdm_clk_d  = 1'b0;
      ones_d     = '0;
      samp_cnt_d = '0;
    end else begin
      div_cnt_d = (div_cnt_q == c_div_last) ? '0 : div_cnt_q + c_div_w'(1);
      pdm_clk_d = (div_cnt_q < c_div_half);
      if (strobe) begin
        if (samp_cnt_q == c_win_last) begin
          // Last sample of the window: report including this sample.
          cntr_d       = ones_sum;
          cntr_valid_d = 1'b1;
          ones_d       = '0;
          samp_cnt_d   = '0;
        end else begin
          ones_d     = ones_sum;
          samp_cnt_d = samp_cnt_q + 10'd1;
        end
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      pdm_clk_q    <= 1'b0;
      ones_q       <= '0;
      samp_cnt_q   <= '0;
      cntr_q       <= '0;
      cntr_valid_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pdm_clk_q    <= pdm_clk_d;
      ones_q       <= ones_d;
      samp_cnt_q   <= samp_cnt_d;
      cntr_q       <= cntr_d;
      cntr_valid_q <= cntr_valid_d;
    end
  end

  assign pdm_clk    = pdm_clk_q;
  assign cntr       = cntr_q;
  assign cntr_valid = cntr_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_counter
// Description : Self-checking bench for pdm_counter. Two instances (default
//               parameters and a short 2/8 configuration) share stimulus and
//               are compared every cycle against an edge-index model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       pdm_data;
  logic       a_pclk, b_pclk;
  logic [9:0] a_cntr, b_cntr;
  logic       a_valid, b_valid;

  int total = 0;
  int bad   = 0;
  int run_edges = 0;   // edges taken with en=1 since the last fresh start
  int alt_base  = 0;

  pdm_counter #(.CLK_DIV(4), .WINDOW(1023)) dut_a (
    .clk(clk), .rst(rst), .en(en), .pdm_data(pdm_data),
    .pdm_clk(a_pclk), .cntr(a_cntr), .cntr_valid(a_valid)
  );

  pdm_counter #(.CLK_DIV(2), .WINDOW(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .pdm_data(pdm_data),
    .pdm_clk(b_pclk), .cntr(b_cntr), .cntr_valid(b_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Edge n (1-based since the run began) has phase (n-1) mod CD. The clock is
  // high for phases below CD/2; the sample of index (n-1)/CD is taken at phase
  // CD/2, and a window closes when that sample index is W-1 modulo W.
  int cd_of[2] = '{4, 2};
  int w_of[2]  = '{1023, 8};
  int m_n[2];
  int m_ones[2];
  int m_cntr[2];
  int m_pclk[2];
  int m_valid[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_n[i] <= 0; m_ones[i] <= 0; m_cntr[i] <= 0;
        m_pclk[i] <= 0; m_valid[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!en) begin
          m_n[i] <= 0; m_ones[i] <= 0; m_pclk[i] <= 0; m_valid[i] <= 0;
        end else begin
          automatic int n  = m_n[i] + 1;
          automatic int ph = (n - 1) % cd_of[i];
          automatic int s  = (n - 1) / cd_of[i];
          automatic int o  = m_ones[i] + int'(pdm_data);
          m_n[i]    <= n;
          m_pclk[i] <= (ph < cd_of[i] / 2) ? 1 : 0;
          if (ph == cd_of[i] / 2) begin
            if ((s % w_of[i]) == w_of[i] - 1) begin
              m_cntr[i]  <= o;
              m_valid[i] <= 1;
              m_ones[i]  <= 0;
            end else begin
              m_ones[i]  <= o;
              m_valid[i] <= 0;
            end
          end else begin
            m_valid[i] <= 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("a_pdm_clk", int'(a_pclk), m_pclk[0]);
    chk("a_cntr", int'(a_cntr), m_cntr[0]);
    chk("a_valid", int'(a_valid), m_valid[0]);
    chk("b_pdm_clk", int'(b_pclk), m_pclk[1]);
    chk("b_cntr", int'(b_cntr), m_cntr[1]);
    chk("b_valid", int'(b_valid), m_valid[1]);
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge: drives data, lets one posedge pass, returns at the
  // following negedge.
  task automatic edge_step(input logic d);
    pdm_data = d;
    @(negedge clk);
    if (en) run_edges++;
    else    run_edges = 0;
  endtask

  // 0: zeros, 1: ones, 2: alternating samples starting at alt_base with
  // random data on non-sampling edges, 3: random.
  function automatic logic gen(input int mode);
    logic r;
    r = 1'($urandom_range(0, 1));
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return ((run_edges % 4) == 2) ? (((run_edges / 4 - alt_base) % 2) == 0) : r;
      default: return r;
    endcase
  endfunction

  task automatic wait_valid_a(input int mode, input int limit, output int edges);
    bit found;
    found = 0;
    edges = 0;
    for (int k = 0; k < limit && !found; k++) begin
      edge_step(gen(mode));
      edges++;
      if (a_valid) found = 1;
    end
    if (!found) chk("wait_valid_a_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int   shape [8] = '{1, 1, 0, 0, 1, 1, 0, 0};

  initial begin
    int e;
    rst = 1'b1; en = 1'b0; pdm_data = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a_pclk", int'(a_pclk), 0);
    chk("reset_a_cntr", int'(a_cntr), 0);
    chk("reset_a_valid", int'(a_valid), 0);
    chk("reset_b_cntr", int'(b_cntr), 0);

    // Constant one: first valid 4091 edges after release, then every 4092.
    rst = 1'b0; en = 1'b1; run_edges = 0;
    wait_valid_a(1, 5000, e);
    chk("ones_first_valid_edges", e, 4091);
    chk("ones_cntr", int'(a_cntr), 1023);
    edge_step(1'b1);
    chk("valid_one_cycle", int'(a_valid), 0);
    chk("cntr_holds", int'(a_cntr), 1023);
    wait_valid_a(1, 5000, e);
    chk("valid_period", e + 1, 4092);
    chk("ones_cntr_2", int'(a_cntr), 1023);

    // Alternating samples 1,0,1,... across two consecutive windows.
    alt_base = run_edges / 4 + 1;
    wait_valid_a(2, 5000, e);
    chk("alt_cntr_512", int'(a_cntr), 512);
    wait_valid_a(2, 5000, e);
    chk("alt_cntr_511", int'(a_cntr), 511);

    // Constant zero.
    wait_valid_a(0, 5000, e);
    chk("zero_cntr", int'(a_cntr), 0);

    // Enable drop on the edge that would complete the next window.
    for (int k = 0; k < 4091; k++) edge_step(1'b1);
    en = 1'b0;
    edge_step(1'b1);
    chk("drop_no_valid", int'(a_valid), 0);
    chk("drop_cntr_kept", int'(a_cntr), 0);
    chk("drop_pclk_low", int'(a_pclk), 0);
    repeat (3) edge_step(1'b1);
    chk("disabled_pclk_low", int'(a_pclk), 0);
    en = 1'b1;
    wait_valid_a(1, 5000, e);
    chk("reenable_first_valid", e, 4091);
    chk("reenable_cntr", int'(a_cntr), 1023);

    // Asynchronous reset in a pdm_clk high phase, mid-window.
    for (int k = 0; k < 1001; k++) edge_step(1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pclk", int'(a_pclk), 0);
    chk("async_rst_cntr", int'(a_cntr), 0);
    chk("async_rst_valid", int'(a_valid), 0);
    @(negedge clk);
    rst = 1'b0; run_edges = 0;
    wait_valid_a(1, 5000, e);
    chk("post_rst_first_valid", e, 4091);
    chk("post_rst_cntr", int'(a_cntr), 1023);

    // Short window on instance B; clock shape on instance A; garbage data on
    // edges that are not B sampling edges.
    en = 1'b0;
    repeat (2) edge_step(1'b0);
    en = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      logic d;
      d = 1'($urandom_range(0, 1));
      if ((n % 2) == 0) d = (n <= 16) ? pat[(n / 2 - 1) % 8] : 1'b0;
      edge_step(d);
      if (n <= 8) chk("a_clock_shape", int'(a_pclk), shape[n - 1]);
      if (n == 15) chk("b_no_early_valid", int'(b_valid), 0);
      if (n == 16) begin
        chk("b_short_valid", int'(b_valid), 1);
        chk("b_short_cntr5", int'(b_cntr), 5);
      end
      if (n == 17) chk("b_short_cntr_hold", int'(b_cntr), 5);
      if (n == 32) begin
        chk("b_zero_valid", int'(b_valid), 1);
        chk("b_zero_cntr", int'(b_cntr), 0);
      end
    end

    // Random data with occasional enable drops.
    for (int k = 0; k < 9000; k++) begin
      en = ($urandom_range(0, 2999) != 0);
      edge_step(gen(3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
